// File: rtl/conv_wb_ctrl_gen_if.sv
// Row-side and output-lane handshake bundle for conv_wb_ctrl_gen.
// master: the controller's view; slave: the PE array / output writer view.
interface conv_wb_ctrl_gen_if #(
  parameter int unsigned DATA_W    = 25,
  parameter int unsigned NUM_ROWS  = 5,
  parameter int unsigned NUM_PORTS = 2
);
  logic [NUM_ROWS*DATA_W-1:0]  row_data;
  logic [NUM_ROWS-1:0]         row_valid;
  logic                        row_stall;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS-1:0]        out_valid;
  logic                        out_ready;

  modport master (
    input  row_data, row_valid, out_ready,
    output row_stall, out_data, out_valid
  );

  modport slave (
    output row_data, row_valid, out_ready,
    input  row_stall, out_data, out_valid
  );
endinterface

// File: rtl/conv_wb_ctrl_gen.sv
// Writeback controller: init/start/swap/drain sequencing and row-to-lane muxing.
// Optional macro WB_RELU_EN clamps negative valid lanes to zero.
module conv_wb_ctrl_gen #(
  parameter int unsigned DATA_W    = 25,
  parameter int unsigned DEPTH     = 61,
  parameter int unsigned NUM_ROWS  = 5,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start_init,
  input  logic                  i_p_filter_end,
  input  logic                  i_end_conv,
  conv_wb_ctrl_gen_if.master    io_wb,
  output logic                  o_p_init,
  output logic [NUM_ROWS-1:0]   o_p_write_zero,
  output logic                  o_start_conv,
  output logic                  o_odd_cnt,
  output logic                  o_pattern_err,
  output logic                  o_end_op
);
  localparam int unsigned NUM_GROUPS = (NUM_ROWS + NUM_PORTS - 1) / NUM_PORTS;
  localparam int unsigned GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] CntDepthEnd = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CntStartEnd = CNT_W'(DEPTH + 2);

  typedef enum logic [3:0] {
    StIdle, StInit, StStart, StWaitFilter, StWaitAdd, StSwap, StDrain, StGap, StFinish, StDone
  } state_e;

  state_e                      r_state, w_state_d;
  logic [CNT_W-1:0]            r_cnt, w_cnt_d;
  logic [GRP_W-1:0]            r_grp, w_grp_d;
  logic                        r_end_pending, w_end_pending_d;
  logic                        r_p_init, w_p_init_d;
  logic [NUM_ROWS-1:0]         r_p_write_zero, w_p_write_zero_d;
  logic                        r_start_conv, w_start_conv_d;
  logic                        r_odd_cnt, w_odd_cnt_d;
  logic                        r_end_op, w_end_op_d;
  logic                        r_pattern_err, w_pattern_err_d;
  logic [NUM_PORTS*DATA_W-1:0] r_out_data, w_lane_data;
  logic [NUM_PORTS-1:0]        r_out_valid, w_lane_valid;
  logic                        w_row_stall, w_last_grp, w_load, w_hit;
  int unsigned                 w_hit_grp;

  function automatic logic [NUM_ROWS-1:0] group_mask(input int unsigned g);
    logic [NUM_ROWS-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < NUM_ROWS; k++) m[k] = ((k / NUM_PORTS) == g);
    return m;
  endfunction

  assign w_row_stall = (|r_out_valid) & ~io_wb.out_ready;
  assign w_last_grp  = (r_grp == GRP_W'(NUM_GROUPS - 1));
  assign w_load      = ~(|r_out_valid) | io_wb.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:       if (i_start_init) w_state_d = StInit;
      StInit:       if (r_cnt == CntDepthEnd) w_state_d = StStart;
      StStart:      if (r_cnt == CntStartEnd) w_state_d = StWaitFilter;
      StWaitFilter: if (i_p_filter_end) w_state_d = StWaitAdd;
      StWaitAdd:    if (r_cnt == CntDepthEnd) w_state_d = StSwap;
      StSwap:       w_state_d = StDrain;
      StDrain:      if (!w_row_stall && r_cnt == CntDepthEnd) w_state_d = StGap;
      StGap: begin
        if (!w_last_grp)        w_state_d = StDrain;
        else if (r_end_pending) w_state_d = StFinish;
        else                    w_state_d = StWaitFilter;
      end
      StFinish:     if (!(|r_out_valid)) w_state_d = StDone;
      StDone:       w_state_d = StIdle;
      default:      w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_p_init_d       = (r_state == StInit);
    w_start_conv_d   = (r_state == StStart) || (r_state == StSwap);
    w_p_write_zero_d = '0;
    if (r_state == StDrain && !w_row_stall) w_p_write_zero_d = group_mask(32'(r_grp));
    w_odd_cnt_d      = (r_state == StSwap) ? ~r_odd_cnt : r_odd_cnt;
    w_end_op_d       = (r_state == StDone);
  end

  // Counter restarts on every state change so each counted state begins at zero.
  always_comb begin
    w_cnt_d = r_cnt + CNT_W'(1);
    if (w_state_d != r_state) begin
      w_cnt_d = '0;
    end else begin
      case (r_state)
        StIdle, StGap, StSwap, StWaitFilter, StFinish: w_cnt_d = '0;
        StDrain: if (w_row_stall) w_cnt_d = r_cnt;
        default: ;
      endcase
    end
    w_grp_d = r_grp;
    if (r_state == StIdle)     w_grp_d = '0;
    else if (r_state == StGap) w_grp_d = w_last_grp ? '0 : r_grp + GRP_W'(1);
    w_end_pending_d = (r_state == StFinish) ? 1'b0 : (r_end_pending | i_end_conv);
  end

  always_comb begin
    logic [DATA_W-1:0] word;
    int unsigned       idx;
    w_hit        = 1'b0;
    w_hit_grp    = 0;
    w_lane_data  = '0;
    w_lane_valid = '0;
    word         = '0;
    idx          = 0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      if (io_wb.row_valid == group_mask(g)) begin
        w_hit     = 1'b1;
        w_hit_grp = g;
      end
    end
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      idx = w_hit_grp * NUM_PORTS + j;
      if (w_hit && idx < NUM_ROWS) begin
        word = io_wb.row_data[idx*DATA_W +: DATA_W];
`ifdef WB_RELU_EN
        if (word[DATA_W-1]) word = '0;
`endif
        w_lane_data[j*DATA_W +: DATA_W] = word;
        w_lane_valid[j]                 = 1'b1;
      end
    end
    w_pattern_err_d = r_pattern_err;
    if (r_state == StIdle && i_start_init) w_pattern_err_d = 1'b0;
    if (w_load && (|io_wb.row_valid) && !w_hit) w_pattern_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_grp          <= '0;
      r_end_pending  <= 1'b0;
      r_p_init       <= 1'b0;
      r_p_write_zero <= '0;
      r_start_conv   <= 1'b0;
      r_odd_cnt      <= 1'b0;
      r_end_op       <= 1'b0;
      r_pattern_err  <= 1'b0;
      r_out_data     <= '0;
      r_out_valid    <= '0;
    end else begin
      r_cnt          <= w_cnt_d;
      r_grp          <= w_grp_d;
      r_end_pending  <= w_end_pending_d;
      r_p_init       <= w_p_init_d;
      r_p_write_zero <= w_p_write_zero_d;
      r_start_conv   <= w_start_conv_d;
      r_odd_cnt      <= w_odd_cnt_d;
      r_end_op       <= w_end_op_d;
      r_pattern_err  <= w_pattern_err_d;
      if (w_load) begin
        r_out_data  <= w_lane_data;
        r_out_valid <= w_lane_valid;
      end
    end
  end

  assign io_wb.out_data  = r_out_data;
  assign io_wb.out_valid = r_out_valid;
  assign io_wb.row_stall = w_row_stall;
  assign o_p_init        = r_p_init;
  assign o_p_write_zero  = r_p_write_zero;
  assign o_start_conv    = r_start_conv;
  assign o_odd_cnt       = r_odd_cnt;
  assign o_pattern_err   = r_pattern_err;
  assign o_end_op        = r_end_op;
endmodule

// File: tb/tb_conv_wb_ctrl_gen.sv
// Bench for conv_wb_ctrl_gen (DEPTH=4): vector table, FSM sequences, randomized lane model.
module tb_conv_wb_ctrl_gen;
  localparam int unsigned DATA_W    = 25;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned NUM_ROWS  = 5;
  localparam int unsigned NUM_PORTS = 2;

  logic clk = 1'b0;
  logic rst, start_init, p_filter_end, end_conv;
  logic p_init, start_conv, odd_cnt, pattern_err, end_op;
  logic [NUM_ROWS-1:0] p_write_zero;

  conv_wb_ctrl_gen_if #(.DATA_W(DATA_W), .NUM_ROWS(NUM_ROWS), .NUM_PORTS(NUM_PORTS)) wb ();

  conv_wb_ctrl_gen #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_ROWS(NUM_ROWS), .NUM_PORTS(NUM_PORTS), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start_init  (start_init),
    .i_p_filter_end(p_filter_end),
    .i_end_conv    (end_conv),
    .io_wb         (wb),
    .o_p_init      (p_init),
    .o_p_write_zero(p_write_zero),
    .o_start_conv  (start_conv),
    .o_odd_cnt     (odd_cnt),
    .o_pattern_err (pattern_err),
    .o_end_op      (end_op)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [124:0] pack5(input int a, input int b, input int c, input int d,
                                         input int e);
    return {25'(e), 25'(d), 25'(c), 25'(b), 25'(a)};
  endfunction

  // Lane model: the lowest valid row names the group; row_valid must be exactly that group's rows.
  function automatic void ref_lanes(input logic [4:0] rv, input logic [124:0] rd,
                                    output logic [49:0] d, output logic [1:0] v, output bit bad);
    int lo, g, n;
    logic [4:0]  want;
    logic [24:0] w;
    d = '0; v = '0; bad = 0;
    if (rv == 5'd0) return;
    lo = 0;
    while (!rv[lo]) lo++;
    g = lo / NUM_PORTS;
    n = NUM_ROWS - g * NUM_PORTS;
    if (n > NUM_PORTS) n = NUM_PORTS;
    want = 5'(((1 << n) - 1) << (g * NUM_PORTS));
    if (rv != want) begin
      bad = 1;
      return;
    end
    for (int j = 0; j < n; j++) begin
      w = rd[(g*NUM_PORTS+j)*DATA_W +: DATA_W];
`ifdef WB_RELU_EN
      if (w[24]) w = '0;
`endif
      d[j*DATA_W +: DATA_W] = w;
      v[j] = 1'b1;
    end
  endfunction

  typedef struct {
    logic [4:0]   rv;
    logic [124:0] rd;
    logic [24:0]  e0;
    logic [24:0]  e1;
    logic [1:0]   ev;
    logic         eperr;
  } vec_t;

`ifdef WB_RELU_EN
  localparam logic [24:0] ExpNeg5 = 25'd0;
  localparam logic [24:0] ExpNeg3 = 25'd0;
`else
  localparam logic [24:0] ExpNeg5 = 25'h1FFFFFB;
  localparam logic [24:0] ExpNeg3 = 25'h1FFFFFD;
`endif

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_pass(input bit with_end, input bit with_stall, input bit exp_odd,
                          input string tag);
    int c_pwz[NUM_ROWS];
    int c_sc, c_eop, phase;
    c_sc = 0; c_eop = 0; phase = 0;
    for (int k = 0; k < NUM_ROWS; k++) c_pwz[k] = 0;
    p_filter_end = 1'b1;
    @(negedge clk);
    p_filter_end = 1'b0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      for (int k = 0; k < NUM_ROWS; k++) if (p_write_zero[k]) c_pwz[k]++;
      if (start_conv) c_sc++;
      if (end_op) c_eop++;
      if (phase == 0 && p_write_zero[0]) begin
        wb.row_valid = 5'b00011;
        wb.row_data  = pack5(10, 11, 0, 0, 0);
        end_conv     = with_end;
        phase        = with_stall ? 1 : 4;
      end else if (phase >= 1 && phase <= 3) begin
        wb.row_valid = '0;
        end_conv     = 1'b0;
        wb.out_ready = 1'b0;
        #1;
        check($sformatf("%s_stall%0d", tag, phase), 64'(wb.row_stall), 64'd1);
        check($sformatf("%s_hold%0d", tag, phase), 64'(wb.out_data), 64'({25'd11, 25'd10}));
        check($sformatf("%s_hvld%0d", tag, phase), 64'(wb.out_valid), 64'd3);
        phase++;
      end else if (phase == 4) begin
        wb.row_valid = '0;
        end_conv     = 1'b0;
        wb.out_ready = 1'b1;
        phase        = 5;
      end
      @(negedge clk);
    end
    check({tag, "_drain_seen"}, 64'(phase), 64'd5);
    for (int k = 0; k < NUM_ROWS; k++)
      check($sformatf("%s_pwz_row%0d", tag, k), 64'(c_pwz[k]), 64'(DEPTH));
    check({tag, "_swap_start_conv"}, 64'(c_sc), 64'd1);
    check({tag, "_end_op_pulses"}, 64'(c_eop), 64'(with_end));
    check({tag, "_odd_cnt"}, 64'(odd_cnt), 64'(exp_odd));
  endtask

  initial begin
    vec_t        vecs[8];
    int          c_init, c_sc, c_eop;
    logic [49:0] exp_d, nd;
    logic [1:0]  exp_v, nv;
    logic        exp_perr;
    bit          bad;
    logic [4:0]  rv;

    vecs[0] = '{5'b00011, pack5(10, 11, 0, 0, 0),   25'd10,  25'd11, 2'b11, 1'b0};
    vecs[1] = '{5'b01100, pack5(0, 0, 20, 21, 0),   25'd20,  25'd21, 2'b11, 1'b0};
    vecs[2] = '{5'b10000, pack5(1, 2, 3, 4, 7),     25'd7,   25'd0,  2'b01, 1'b0};
    vecs[3] = '{5'b00000, pack5(9, 9, 9, 9, 9),     25'd0,   25'd0,  2'b00, 1'b0};
    vecs[4] = '{5'b00011, pack5(-5, 3, 0, 0, 0),    ExpNeg5, 25'd3,  2'b11, 1'b0};
    vecs[5] = '{5'b00101, pack5(1, 2, 3, 4, 5),     25'd0,   25'd0,  2'b00, 1'b1};
    vecs[6] = '{5'b01100, pack5(0, 0, 5, 6, 0),     25'd5,   25'd6,  2'b11, 1'b1};
    vecs[7] = '{5'b10000, pack5(0, 0, 0, 0, -3),    ExpNeg3, 25'd0,  2'b01, 1'b1};

    rst = 1'b1; start_init = 1'b0; p_filter_end = 1'b0; end_conv = 1'b0;
    wb.row_data = '0; wb.row_valid = '0; wb.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_p_init", 64'(p_init), 64'd0);
    check("rst_pwz", 64'(p_write_zero), 64'd0);
    check("rst_start_conv", 64'(start_conv), 64'd0);
    check("rst_odd_cnt", 64'(odd_cnt), 64'd0);
    check("rst_out_valid", 64'(wb.out_valid), 64'd0);
    check("rst_out_data", 64'(wb.out_data), 64'd0);
    check("rst_pattern_err", 64'(pattern_err), 64'd0);
    check("rst_end_op", 64'(end_op), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      wb.row_valid = vecs[i].rv;
      wb.row_data  = vecs[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d_data", i), 64'(wb.out_data), 64'({vecs[i].e1, vecs[i].e0}));
      check($sformatf("vec%0d_valid", i), 64'(wb.out_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d_perr", i), 64'(pattern_err), 64'(vecs[i].eperr));
    end
    wb.row_valid = '0;
    do_reset();

    start_init = 1'b1;
    @(negedge clk);
    start_init = 1'b0;
    c_init = 0; c_sc = 0; c_eop = 0;
    repeat (20) begin
      if (p_init) c_init++;
      if (start_conv) c_sc++;
      if (end_op) c_eop++;
      @(negedge clk);
    end
    check("init_cycles", 64'(c_init), 64'(DEPTH));
    check("start_conv_cycles", 64'(c_sc), 64'(DEPTH + 3));
    check("init_end_op", 64'(c_eop), 64'd0);

    start_init = 1'b1;
    @(negedge clk);
    start_init = 1'b0;
    c_init = 0;
    repeat (10) begin
      if (p_init) c_init++;
      @(negedge clk);
    end
    check("start_init_ignored", 64'(c_init), 64'd0);

    run_pass(1'b0, 1'b1, 1'b1, "pass1");
    run_pass(1'b1, 1'b0, 1'b0, "pass2");

    p_filter_end = 1'b1;
    @(negedge clk);
    p_filter_end = 1'b0;
    c_sc = 0;
    repeat (15) begin
      if (start_conv || (|p_write_zero)) c_sc++;
      @(negedge clk);
    end
    check("filter_end_ignored", 64'(c_sc), 64'd0);

    do_reset();
    exp_d = '0; exp_v = '0; exp_perr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      check("rnd_data", 64'(wb.out_data), 64'(exp_d));
      check("rnd_valid", 64'(wb.out_valid), 64'(exp_v));
      check("rnd_perr", 64'(pattern_err), 64'(exp_perr));
      case ($urandom_range(0, 3))
        0, 3: begin
          case ($urandom_range(0, 2))
            0:       rv = 5'b00011;
            1:       rv = 5'b01100;
            default: rv = 5'b10000;
          endcase
        end
        1:       rv = 5'($urandom);
        default: rv = 5'd0;
      endcase
      wb.row_valid = rv;
      for (int r = 0; r < NUM_ROWS; r++) wb.row_data[r*DATA_W +: DATA_W] = 25'($urandom);
      wb.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_row_stall", 64'(wb.row_stall), 64'((|exp_v) && !wb.out_ready));
      if (exp_v == 2'b00 || wb.out_ready) begin
        ref_lanes(rv, wb.row_data, nd, nv, bad);
        exp_d = nd;
        exp_v = nv;
        if (bad) exp_perr = 1'b1;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
